// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch and data), the arbiter and memory.
//
// Handshake: a requester raises *_req with its address/kind/data stable and keeps
// it high until it sees its one-cycle *_done pulse; the arbiter samples the
// request fields only in the grant cycle. Memory sees mem_en for exactly one
// cycle per access and answers reads with a one-cycle mem_valid strobe carrying
// mem_rdata; writes complete after a fixed latency with no strobe.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  // Requester/memory side
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// memory. One access at a time, sequenced IDLE -> ISSUE -> WAIT -> DONE.
// Data normally wins, but a fetch is granted right after a data access so a
// continuously requesting data port cannot starve fetches. Reads that see no
// mem_valid within TIMEOUT cycles are abandoned and raise the sticky err flag.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int TIMEOUT     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_arbiter_if.slave       bus,
  output logic               busy,
  output logic               err,
  output logic [1:0]         o_dbg_state
);

  localparam int CNT_MAX = (MEM_LATENCY > TIMEOUT) ? MEM_LATENCY : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [CW-1:0] r_cnt;
  logic        r_gnt_data;   // current access belongs to the data port
  logic        r_wr;         // current access is a store
  logic        r_last_data;  // last completed access was a data access
  logic        r_mem_en;
  logic        r_mem_wr;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_i_done;
  logic        r_d_done;
  logic [15:0] r_i_rdata;
  logic [15:0] r_d_rdata;
  logic        r_busy;
  logic        r_err;

  logic        w_pick_data;
  logic        w_is_read;
  logic        w_wait_end;
  logic        w_grant;
  logic        w_capture;
  logic        w_timeout;
  logic        w_finish;

  // Data wins unless the previous access was data and a fetch is pending.
  assign w_pick_data = bus.d_req & ~(r_last_data & bus.i_req);
  assign w_is_read   = ~(r_gnt_data & r_wr);
  // Reads end on mem_valid or timeout; stores end after the fixed latency.
  assign w_wait_end  = w_is_read ? (bus.mem_valid | (r_cnt >= CW'(TIMEOUT)))
                                 : (r_cnt >= CW'(MEM_LATENCY));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_req | bus.d_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_wait_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state event strobes feeding the output registers
  always_comb begin
    w_grant   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_IDLE: w_grant = bus.i_req | bus.d_req;
      S_WAIT: begin
        w_capture = w_is_read & bus.mem_valid;
        w_timeout = w_is_read & ~bus.mem_valid & (r_cnt >= CW'(TIMEOUT));
        w_finish  = w_wait_end;
      end
      default: ;
    endcase
  end

  // Registered outputs, grant latches, cycle counter and priority history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_gnt_data  <= 1'b0;
      r_wr        <= 1'b0;
      r_last_data <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_i_rdata   <= 16'h0000;
      r_d_rdata   <= 16'h0000;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_en <= w_grant;
      r_mem_wr <= w_grant & w_pick_data & bus.d_wr;
      r_i_done <= w_finish & ~r_gnt_data;
      r_d_done <= w_finish & r_gnt_data;
      r_busy   <= (w_next != S_IDLE);

      if (w_grant) begin
        r_gnt_data <= w_pick_data;
        r_wr       <= w_pick_data & bus.d_wr;
        r_mem_addr <= w_pick_data ? bus.d_addr : bus.i_addr;
        if (w_pick_data && bus.d_wr) r_mem_wdata <= bus.d_wdata;
      end

      if (r_state == S_ISSUE)                 r_cnt <= CW'(1);
      else if (r_state == S_WAIT && !w_wait_end) r_cnt <= r_cnt + CW'(1);
      else                                    r_cnt <= '0;

      if (w_capture) begin
        if (r_gnt_data) r_d_rdata <= bus.mem_rdata;
        else            r_i_rdata <= bus.mem_rdata;
      end

      if (w_timeout) r_err <= 1'b1;

      if (r_state == S_DONE) r_last_data <= r_gnt_data;
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_done    = r_i_done;
  assign bus.d_done    = r_d_done;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign busy          = r_busy;
  assign err           = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (MEM_LATENCY=4, TIMEOUT=8): cycle-by-cycle vector table
// for store / fetch / simultaneous-request traffic, then hand-written sequences
// for fetch-starvation, read timeout and reset in the middle of an access.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_LATENCY(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .err        (err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  typedef struct {
    logic        ir;   logic [15:0] ia;
    logic        dr;   logic dw; logic [15:0] da; logic [15:0] dd;
    logic        mv;   logic [15:0] mrd;
    logic [1:0]  st;   logic en; logic wr;
    logic [15:0] addr; logic [15:0] wd;
    logic        idn;  logic ddn;
    logic [15:0] ird;  logic [15:0] drd;
    logic        bsy;  logic er;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // {state, mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata, busy, err}
  function automatic logic [71:0] pack_dut();
    return {dbg_state, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
            bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata, busy, err};
  endfunction

  function automatic logic [71:0] pack_exp(input vec_t v);
    return {v.st, v.en, v.wr, v.addr, v.wd, v.idn, v.ddn, v.ird, v.drd, v.bsy, v.er};
  endfunction

  task automatic add(input logic ir, input logic [15:0] ia,
                     input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                     input logic mv, input logic [15:0] mrd,
                     input logic [1:0] st, input logic en, input logic wr,
                     input logic [15:0] addr, input logic [15:0] wd,
                     input logic idn, input logic ddn,
                     input logic [15:0] ird, input logic [15:0] drd,
                     input logic bsy, input logic er);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.mv = mv; v.mrd = mrd; v.st = st; v.en = en; v.wr = wr;
    v.addr = addr; v.wd = wd; v.idn = idn; v.ddn = ddn;
    v.ird = ird; v.drd = drd; v.bsy = bsy; v.er = er;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic [15:0] ia,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                       input logic mv, input logic [15:0] mrd);
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_wr = dw; bus.d_addr = da; bus.d_wdata = dd;
    bus.mem_valid = mv; bus.mem_rdata = mrd;
  endtask

  // Wait (bounded) for an output event: 0 = mem_en, 1 = d_done, 2 = i_done.
  task automatic wait_for(input int sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      case (sel)
        0: ok = bus.mem_en;
        1: ok = bus.d_done;
        default: ok = bus.i_done;
      endcase
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    bit ok;
    int both;
    int bad;

    rst_n = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

    // Store 0300 <= 1234 (mem_valid asserted but must be ignored)
    add(0,16'h0, 1,1,16'h0300,16'h1234, 0,16'h0,    2'd1,1,1,16'h0300,16'h1234, 0,0,16'h0,16'h0, 1,0);
    for (int k = 0; k < 4; k++)
      add(0,16'h0, 1,1,16'h0300,16'h1234, 1,16'h5555, 2'd2,0,0,16'h0300,16'h1234, 0,0,16'h0,16'h0, 1,0);
    add(0,16'h0, 1,1,16'h0300,16'h1234, 1,16'h5555, 2'd3,0,0,16'h0300,16'h1234, 0,1,16'h0,16'h0, 1,0);
    add(0,16'h0, 0,0,16'h0,16'h0,       0,16'h0,    2'd0,0,0,16'h0300,16'h1234, 0,0,16'h0,16'h0, 0,0);
    // Fetch 0010, mem_valid 4 cycles after issue with B0A5
    add(1,16'h0010, 0,0,16'h0,16'h0, 0,16'h0,    2'd1,1,0,16'h0010,16'h1234, 0,0,16'h0,16'h0, 1,0);
    for (int k = 0; k < 4; k++)
      add(1,16'h0010, 0,0,16'h0,16'h0, 0,16'h0,  2'd2,0,0,16'h0010,16'h1234, 0,0,16'h0,16'h0, 1,0);
    add(1,16'h0010, 0,0,16'h0,16'h0, 1,16'hB0A5, 2'd3,0,0,16'h0010,16'h1234, 1,0,16'hB0A5,16'h0, 1,0);
    add(0,16'h0,    0,0,16'h0,16'h0, 0,16'hDEAD, 2'd0,0,0,16'h0010,16'h1234, 0,0,16'hB0A5,16'h0, 0,0);
    add(0,16'h0,    0,0,16'h0,16'h0, 1,16'hFFFF, 2'd0,0,0,16'h0010,16'h1234, 0,0,16'hB0A5,16'h0, 0,0);
    // Simultaneous: load 0200 first (valid during ISSUE ignored), then fetch 0044
    add(1,16'h0044, 1,0,16'h0200,16'h0, 0,16'h0,    2'd1,1,0,16'h0200,16'h1234, 0,0,16'hB0A5,16'h0, 1,0);
    add(1,16'h0044, 1,0,16'h0200,16'h0, 1,16'h1111, 2'd2,0,0,16'h0200,16'h1234, 0,0,16'hB0A5,16'h0, 1,0);
    add(1,16'h0044, 1,0,16'h0200,16'h0, 1,16'h7777, 2'd3,0,0,16'h0200,16'h1234, 0,1,16'hB0A5,16'h7777, 1,0);
    add(1,16'h0044, 0,0,16'h0,16'h0,    0,16'h0,    2'd0,0,0,16'h0200,16'h1234, 0,0,16'hB0A5,16'h7777, 0,0);
    add(1,16'h0044, 0,0,16'h0,16'h0,    0,16'h0,    2'd1,1,0,16'h0044,16'h1234, 0,0,16'hB0A5,16'h7777, 1,0);
    add(1,16'h0044, 0,0,16'h0,16'h0,    0,16'h0,    2'd2,0,0,16'h0044,16'h1234, 0,0,16'hB0A5,16'h7777, 1,0);
    add(1,16'h0044, 0,0,16'h0,16'h0,    1,16'h2222, 2'd3,0,0,16'h0044,16'h1234, 1,0,16'h2222,16'h7777, 1,0);
    add(0,16'h0,    0,0,16'h0,16'h0,    1,16'h3333, 2'd0,0,0,16'h0044,16'h1234, 0,0,16'h2222,16'h7777, 0,0);

    repeat (3) @(negedge clk);
    check("reset_state", pack_dut(), 72'h0);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].dd,
            vecs[k].mv, vecs[k].mrd);
      @(negedge clk);
      check($sformatf("vec%0d", k), pack_dut(), pack_exp(vecs[k]));
    end

    // ---- starvation: both held high, grants must alternate D, I, D, I ----
    exp_q = '{16'h0A00, 16'h0B00, 16'h0A00, 16'h0B00};
    got_q.delete();
    both = 0;
    drive(1, 16'h0B00, 1, 0, 16'h0A00, 16'h0, 1, 16'h4444);
    for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
      @(negedge clk);
      if (bus.i_done && bus.d_done) both++;
      if (bus.mem_en) got_q.push_back(bus.mem_addr);
    end
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h4444);
    for (int c = 0; c < 20 && busy; c++) begin
      @(negedge clk);
      if (bus.i_done && bus.d_done) both++;
    end
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    check("starve_count", 72'(got_q.size()), 72'(exp_q.size()));
    for (int g = 0; g < 4; g++) begin
      if (g < got_q.size())
        check($sformatf("starve_grant%0d", g), 72'(got_q[g]), 72'(exp_q[g]));
    end
    check("starve_no_double_done", 72'(both), 72'd0);
    check("starve_idle", {70'(busy), dbg_state}, 72'd0);

    // ---- read timeout: load 0500, mem_valid never comes ----
    bad = 0;
    drive(0, 16'h0, 1, 0, 16'h0500, 16'h0, 0, 16'h0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (bus.d_done || bus.i_done || err) bad++;
    end
    check("tmo_before_limit", {40'(bad), 30'h0, dbg_state, busy, err},
          {40'd0, 30'h0, 2'd2, 1'b1, 1'b0});
    @(negedge clk);
    check("tmo_done", pack_dut(),
          {2'd3, 1'b0, 1'b0, 16'h0500, 16'h1234, 1'b0, 1'b1, 16'h4444, 16'h4444, 1'b1, 1'b1});
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    @(negedge clk);
    check("tmo_idle", pack_dut(),
          {2'd0, 1'b0, 1'b0, 16'h0500, 16'h1234, 1'b0, 1'b0, 16'h4444, 16'h4444, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    check("err_sticky", 72'(err), 72'd1);

    // ---- reset in the middle of a fetch ----
    drive(1, 16'h0600, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    repeat (3) @(negedge clk);
    check("rst_pre_wait", 72'(dbg_state), 72'd2);
    rst_n = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    #1;
    check("rst_mid_outputs", pack_dut(), 72'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.i_done || bus.d_done || busy) bad++;
    end
    check("rst_no_done", 72'(bad), 72'd0);

    // After reset the history says "last was fetch", so data wins first.
    drive(1, 16'h0700, 1, 0, 16'h0800, 16'h0, 1, 16'h9999);
    wait_for(0, 10, ok);
    check("post_rst_first_grant", {71'(bus.mem_addr), ok}, {71'(16'h0800), 1'b1});
    wait_for(1, 20, ok);
    check("post_rst_d_done", {55'(bus.d_rdata), ok}, {55'(16'h9999), 1'b1});
    bus.d_req = 1'b0;
    wait_for(2, 20, ok);
    check("post_rst_fetch", {38'h0, bus.mem_addr, bus.i_rdata, bus.mem_wr, ok},
          {38'h0, 16'h0700, 16'h9999, 1'b0, 1'b1});
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    repeat (2) @(negedge clk);
    check("final_idle", {69'(err), busy, dbg_state}, 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4: cycles from the memory issue cycle to mem_valid for reads, and the fixed completion time for writes.
REQ-002 Parameter TIMEOUT, default 8: cycles after issue after which a read with no mem_valid is abandoned.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req  input  1  instruction-fetch request; held high until i_done.
REQ-006 i_addr  input  16  fetch address; sampled at grant.
REQ-007 i_done  output  1  one-cycle pulse: fetch complete.
REQ-008 i_rdata  output  16  fetch data; valid with i_done, held until the next fetch completes.
REQ-009 d_req  input  1  data request; held high until d_done.
REQ-010 d_wr  input  1  1 = store, 0 = load; sampled at grant.
REQ-011 d_addr  input  16  data address; sampled at grant.
REQ-012 d_wdata  input  16  store data; sampled at grant.
REQ-013 d_done  output  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  output  16  load data; valid with d_done, held until the next load completes.
REQ-015 mem_en  output  1  memory enable; high for exactly the one issue cycle.
REQ-016 mem_wr  output  1  memory write strobe; high only with mem_en on a store.
REQ-017 mem_addr  output  16  latched access address; stable for the whole access.
REQ-018 mem_wdata  output  16  latched store data.
REQ-019 mem_rdata  input  16  memory read data; valid when mem_valid is high.
REQ-020 mem_valid  input  1  memory read-data strobe.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 err  output  1  sticky flag: a read timed out; cleared only by reset.

Function
REQ-023 States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
REQ-024 IDLE: if any request is high at the clock edge, grant it, latch its address, data and kind, and go to ISSUE.
REQ-025 Priority: d_req wins over i_req, except when the previous completed access was a data access and i_req is high; then i_req is granted (no fetch starvation).
REQ-026 ISSUE lasts 1 cycle: mem_en=1, mem_wr=latched d_wr for a data grant (0 for a fetch); then go to WAIT with the cycle counter cnt=1.
REQ-027 WAIT, read: cnt increments each cycle; when mem_valid=1, capture mem_rdata into the granted port's rdata register and go to DONE.
REQ-028 WAIT, write: go to DONE when cnt reaches MEM_LATENCY; mem_valid is ignored.
REQ-029 WAIT, read: if cnt reaches TIMEOUT with no mem_valid, set err, leave rdata unchanged, and go to DONE.
REQ-030 DONE lasts 1 cycle: pulse the granted port's done, then return to IDLE.
REQ-031 The next grant occurs at the earliest in the IDLE cycle after DONE; minimum back-to-back spacing is ISSUE+WAIT+DONE+IDLE.
REQ-032 Read latency: req sampled at edge E -> i_done/d_done high in cycle E+MEM_LATENCY+2 when mem_valid arrives exactly MEM_LATENCY cycles after issue.
REQ-033 A request dropped after grant does not abort the access; done still pulses.
REQ-034 mem_valid in IDLE, ISSUE or DONE is ignored; i_done and d_done are never high in the same cycle.
REQ-035 mem_addr and mem_wdata hold their values outside an access; mem_en and mem_wr are 0 outside ISSUE.

Reset
REQ-036 rst_n low, at any time including mid-access: state=IDLE, cnt=0, all outputs 0 (rdata registers=16'h0000, err=0), priority history = "last was fetch"; an in-flight access is discarded with no done pulse.

Verification
REQ-037 Fetch only: i_req=1, i_addr=16'h0010, mem_valid 4 cycles after issue with mem_rdata=16'hB0A5 -> one mem_en pulse with mem_addr=16'h0010, mem_wr=0; i_done pulses once; i_rdata=16'hB0A5 and held.
REQ-038 Simultaneous requests: d_req (load 16'h0200) and i_req rise together -> data is granted first and d_done pulses; then the fetch is granted with no idle gap beyond REQ-031.
REQ-039 Store: d_wr=1, d_addr=16'h0300, d_wdata=16'h1234 -> mem_en=mem_wr=1 for one cycle with matching addr/data; d_done exactly MEM_LATENCY cycles after issue plus 1; d_rdata unchanged.
REQ-040 Starvation: d_req held high continuously plus i_req -> grants alternate D, I, D, I.
REQ-041 Timeout: load with mem_valid never asserted -> err=1 at cnt=TIMEOUT, d_done pulses, d_rdata keeps its previous value, busy drops.
REQ-042 Reset mid-WAIT: rst_n low for 1 cycle during a fetch -> no i_done; all outputs 0; a subsequent fetch completes normally.
